// File: rtl/adc0809_scan_sequencer.sv
// ADC0809 scan sequencer: period timer, multi-channel scan, optional
// per-channel averaging, EOC timeout and overrun detection.
module adc0809_scan_sequencer #(
    parameter int NUM_CH        = 2,
    parameter int SAMPLE_PERIOD = 2700,
    parameter int CLK_DIV       = 25,
    parameter int START_CYC     = 4,
    parameter int OE_CYC        = 4,
    parameter int AVG_LOG2      = 0,
    parameter int TIMEOUT       = 4096
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [7:0]            adc_data_in,
    input  logic                  adc_eoc,
    output logic                  adc_clk,
    output logic                  adc_start,
    output logic                  oe,
    output logic                  addr_a,
    output logic                  addr_b,
    output logic                  addr_c,
    output logic [8*NUM_CH-1:0]   ch_data,
    output logic                  ch_valid,
    output logic [2:0]            ch_id,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_START, S_WAIT_LO, S_WAIT_HI, S_READ, S_ACC, S_FDONE
    } state_e;

    localparam int NCONV = 1 << AVG_LOG2;

    state_e                 state_q, state_d;
    logic [31:0]            div_q, tmr_q, cnt_q, cnt_d;
    logic                   adc_clk_q;
    logic [1:0]             eoc_sync_q;
    logic                   eoc_s, trigger;
    logic [2:0]             ch_q, ch_d, ch_id_q;
    logic [4:0]             conv_q, conv_d;
    logic [11:0]            acc_q, acc_d, sum;
    logic [7:0]             samp_q, samp_d, wdata;
    logic [NUM_CH-1:0][7:0] data_q;
    logic                   wr_en, adv, to_hit;
    logic                   ch_valid_q, frame_done_q, overrun_q, timeout_q;

    assign eoc_s   = eoc_sync_q[1];
    assign trigger = enable && (tmr_q == 32'(SAMPLE_PERIOD - 1));
    assign sum     = acc_q + {4'd0, samp_q};
    assign wdata   = 8'(sum >> AVG_LOG2);
    assign to_hit  = ((state_q == S_WAIT_LO) || (state_q == S_WAIT_HI)) &&
                     (cnt_q == 32'(TIMEOUT - 1));

    // Free-running ADC clock divider, independent of the scan FSM.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            adc_clk_q <= 1'b0;
        end else if (div_q == 32'(CLK_DIV - 1)) begin
            div_q     <= '0;
            adc_clk_q <= ~adc_clk_q;
        end else begin
            div_q <= div_q + 32'd1;
        end
    end

    // Frame period timer; held at zero while disabled, wraps on trigger.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                  tmr_q <= '0;
        else if (!enable || trigger) tmr_q <= '0;
        else                         tmr_q <= tmr_q + 32'd1;
    end

    // Two-flop synchronizer for the asynchronous EOC line.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) eoc_sync_q <= 2'b00;
        else        eoc_sync_q <= {eoc_sync_q[0], adc_eoc};
    end

    // Next-state logic; one shared counter times every state, and a
    // channel advance (normal write or timeout) is funnelled through adv.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        conv_d  = conv_q;
        acc_d   = acc_q;
        samp_d  = samp_q;
        wr_en   = 1'b0;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: if (trigger) begin
                ch_d    = '0;
                acc_d   = '0;
                conv_d  = '0;
                cnt_d   = '0;
                state_d = S_ADDR;
            end
            S_ADDR: if (cnt_q == 32'(2 * CLK_DIV - 1)) begin
                cnt_d   = '0;
                state_d = S_START;
            end else cnt_d = cnt_q + 32'd1;
            S_START: if (cnt_q == 32'(START_CYC - 1)) begin
                cnt_d   = '0;
                state_d = S_WAIT_LO;
            end else cnt_d = cnt_q + 32'd1;
            S_WAIT_LO: if (to_hit) adv = 1'b1;
            else begin
                cnt_d = cnt_q + 32'd1;
                if (!eoc_s) state_d = S_WAIT_HI;
            end
            S_WAIT_HI: if (to_hit) adv = 1'b1;
            else if (eoc_s) begin
                cnt_d   = '0;
                state_d = S_READ;
            end else cnt_d = cnt_q + 32'd1;
            S_READ: if (cnt_q == 32'(OE_CYC - 1)) begin
                samp_d  = adc_data_in;
                cnt_d   = '0;
                state_d = S_ACC;
            end else cnt_d = cnt_q + 32'd1;
            S_ACC: begin
                acc_d  = sum;
                conv_d = conv_q + 5'd1;
                if (conv_d < 5'(NCONV)) state_d = S_ADDR;
                else begin
                    wr_en = 1'b1;
                    adv   = 1'b1;
                end
            end
            S_FDONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (adv) begin
            acc_d  = '0;
            conv_d = '0;
            cnt_d  = '0;
            if (ch_q == 3'(NUM_CH - 1)) state_d = S_FDONE;
            else begin
                ch_d    = ch_q + 3'd1;
                state_d = S_ADDR;
            end
        end
    end

    // State, datapath, result registers and sticky error flags.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ch_q         <= '0;
            conv_q       <= '0;
            acc_q        <= '0;
            samp_q       <= '0;
            data_q       <= '0;
            ch_valid_q   <= 1'b0;
            ch_id_q      <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            conv_q       <= conv_d;
            acc_q        <= acc_d;
            samp_q       <= samp_d;
            for (int k = 0; k < NUM_CH; k++)
                if (wr_en && ch_q == 3'(k)) data_q[k] <= wdata;
            ch_valid_q   <= wr_en;
            if (wr_en) ch_id_q <= ch_q;
            frame_done_q <= (state_q == S_FDONE);
            if (trigger && state_q != S_IDLE) overrun_q <= 1'b1;
            if (to_hit) timeout_q <= 1'b1;
        end
    end

    assign adc_clk     = adc_clk_q;
    assign adc_start   = (state_q == S_START);
    assign oe          = (state_q == S_READ);
    assign addr_a      = ch_q[0];
    assign addr_b      = ch_q[1];
    assign addr_c      = ch_q[2];
    assign ch_data     = data_q;
    assign ch_valid    = ch_valid_q;
    assign ch_id       = ch_id_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_adc0809_scan_sequencer.sv
// Directed bench: dut_a uses default parameters (2 channels, no averaging),
// dut_b uses 1 channel, 4x averaging and a 16-cycle period to force overrun.
module tb_adc0809_scan_sequencer;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;

    // ---------------- dut_a ----------------
    logic        rst_n = 1'b0, enable = 1'b0, stuck0 = 1'b0;
    logic [7:0]  a_din = 8'h00;
    logic        a_eoc = 1'b1;
    logic        a_clk, a_start, a_oe, a_aa, a_ab, a_ac, a_vld, a_fd, a_ovr, a_to;
    logic [15:0] a_data;
    logic [2:0]  a_id;

    adc0809_scan_sequencer dut_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable),
        .adc_data_in(a_din), .adc_eoc(a_eoc),
        .adc_clk(a_clk), .adc_start(a_start), .oe(a_oe),
        .addr_a(a_aa), .addr_b(a_ab), .addr_c(a_ac),
        .ch_data(a_data), .ch_valid(a_vld), .ch_id(a_id),
        .frame_done(a_fd), .overrun(a_ovr), .timeout_err(a_to)
    );

    // ---------------- dut_b ----------------
    logic        rst_b_n = 1'b0, en_b = 1'b0;
    logic [7:0]  b_din = 8'h00;
    logic        b_eoc = 1'b1;
    logic        b_clk, b_start, b_oe, b_aa, b_ab, b_ac, b_vld, b_fd, b_ovr, b_to;
    logic [7:0]  b_data;
    logic [2:0]  b_id;

    adc0809_scan_sequencer #(
        .NUM_CH(1), .SAMPLE_PERIOD(16), .CLK_DIV(2), .START_CYC(4),
        .OE_CYC(4), .AVG_LOG2(2), .TIMEOUT(200)
    ) dut_b (
        .sys_clk(sys_clk), .rst_n(rst_b_n), .enable(en_b),
        .adc_data_in(b_din), .adc_eoc(b_eoc),
        .adc_clk(b_clk), .adc_start(b_start), .oe(b_oe),
        .addr_a(b_aa), .addr_b(b_ab), .addr_c(b_ac),
        .ch_data(b_data), .ch_valid(b_vld), .ch_id(b_id),
        .frame_done(b_fd), .overrun(b_ovr), .timeout_err(b_to)
    );

    // ADC model A (EOC 64 cycles after START, ch0=0x5A, ch1=0xD6) and monitor
    int a_scyc[$], a_saddr[$], a_vcyc[$], a_vid[$], a_vdat[$], a_fdc[$], a_ckc[$];
    logic a_st_d = 1'b0, a_ck_d = 1'b0, a_busy = 1'b0;
    logic [2:0] a_ch = 3'd0;
    int a_cnt = 0;
    always @(negedge sys_clk) begin
        if (a_start && !a_st_d) begin
            a_ch = {a_ac, a_ab, a_aa};
            a_scyc.push_back(cyc);
            a_saddr.push_back(int'(a_ch));
            a_busy = 1'b1; a_cnt = 0; a_eoc = 1'b0;
            a_din = (a_ch == 3'd0) ? 8'h5A : 8'hD6;
        end else if (a_busy) begin
            a_cnt++;
            if (a_cnt == 64) begin
                a_busy = 1'b0;
                a_eoc  = !(stuck0 && a_ch == 3'd0);
            end
        end
        a_st_d = a_start;
        if (a_clk && !a_ck_d && a_ckc.size() < 4) a_ckc.push_back(cyc);
        a_ck_d = a_clk;
        if (a_vld) begin
            a_vcyc.push_back(cyc);
            a_vid.push_back(int'(a_id));
            a_vdat.push_back(int'(a_id == 3'd1 ? a_data[15:8] : a_data[7:0]));
        end
        if (a_fd) a_fdc.push_back(cyc);
    end

    // ADC model B (EOC 64 cycles after START, samples 10,11,12,13 repeating)
    int b_scyc[$], b_vdat[$], b_vid[$], b_vst[$], b_fdc[$];
    logic b_st_d = 1'b0, b_busy = 1'b0;
    int b_cnt = 0, b_conv = 0;
    always @(negedge sys_clk) begin
        if (b_start && !b_st_d) begin
            b_scyc.push_back(cyc);
            b_busy = 1'b1; b_cnt = 0; b_eoc = 1'b0;
            b_din  = 8'(10 + (b_conv % 4));
            b_conv++;
        end else if (b_busy) begin
            b_cnt++;
            if (b_cnt == 64) begin b_busy = 1'b0; b_eoc = 1'b1; end
        end
        b_st_d = b_start;
        if (b_vld) begin
            b_vdat.push_back(int'(b_data));
            b_vid.push_back(int'(b_id));
            b_vst.push_back(b_scyc.size());
        end
        if (b_fd) b_fdc.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int rel, base, vb, fb, gap;

    initial begin
        tick(3);
        // ---- reset state of dut_a ----
        check("rst_ctrl", 32'({a_start, a_oe, a_vld, a_fd, a_ovr, a_to, a_clk}), 32'd0);
        check("rst_addr_id", 32'({a_ac, a_ab, a_aa, a_id}), 32'd0);
        check("rst_data", 32'(a_data), 32'd0);

        // ---- dut_b: averaging and overrun ----
        en_b = 1'b1; rst_b_n = 1'b1;
        for (int i = 0; i < 3000 && b_vdat.size() < 2; i++) tick(1);
        check("b_two_results", 32'(b_vdat.size() >= 2), 32'd1);
        check("b_avg0", 32'(b_vdat[0]), 32'd11);
        check("b_id0", 32'(b_vid[0]), 32'd0);
        check("b_starts_frame0", 32'(b_vst[0]), 32'd4);
        check("b_avg1", 32'(b_vdat[1]), 32'd11);
        check("b_starts_frame1", 32'(b_vst[1] - b_vst[0]), 32'd4);
        check("b_overrun", 32'(b_ovr), 32'd1);
        check("b_no_timeout", 32'(b_to), 32'd0);
        gap = b_scyc[4] - b_fdc[0];
        check("b_restart_window", 32'(gap >= 4 && gap <= 19), 32'd1);
        en_b = 1'b0;

        // ---- dut_a: two normal frames ----
        enable = 1'b1; rst_n = 1'b1; rel = cyc;
        for (int i = 0; i < 8000 && a_vid.size() < 4; i++) tick(1);
        check("a_four_results", 32'(a_vid.size() >= 4), 32'd1);
        check("a_first_start", 32'(a_scyc[0]), 32'(rel + 2750));
        check("a_addr_ch0", 32'(a_saddr[0]), 32'd0);
        check("a_addr_ch1", 32'(a_saddr[1]), 32'd1);
        check("a_id0", 32'(a_vid[0]), 32'd0);
        check("a_data0", 32'(a_vdat[0]), 32'h5A);
        check("a_id1", 32'(a_vid[1]), 32'd1);
        check("a_data1", 32'(a_vdat[1]), 32'hD6);
        check("a_fd_after_last", 32'(a_fdc[0]), 32'(a_vcyc[1] + 1));
        check("a_frame_period", 32'(a_scyc[2] - a_scyc[0]), 32'd2700);
        check("a_frame2_data", 32'({a_vid[2], a_vdat[2], a_vid[3], a_vdat[3]}),
              32'({32'd0, 32'h5A, 32'd1, 32'hD6}));
        check("a_ch_data_both", 32'(a_data), 32'hD65A);
        check("a_adc_clk_period", 32'(a_ckc[1] - a_ckc[0]), 32'd50);
        check("a_no_errors", 32'({a_ovr, a_to}), 32'd0);

        // ---- reset asserted during READ ----
        for (int i = 0; i < 4000 && !a_oe; i++) tick(1);
        check("a_reached_read", 32'(a_oe), 32'd1);
        rst_n = 1'b0; #1;
        check("a_rst_read_ctrl", 32'({a_oe, a_start, a_vld, a_fd, a_ovr, a_to}), 32'd0);
        check("a_rst_read_data", 32'(a_data), 32'd0);
        tick(2);
        base = a_scyc.size();
        rst_n = 1'b1; rel = cyc;
        for (int i = 0; i < 4000 && a_scyc.size() <= base; i++) tick(1);
        check("a_start_after_rst", 32'(a_scyc[base]), 32'(rel + 2750));

        // ---- enable dropped mid-frame ----
        enable = 1'b0;
        vb = a_vid.size(); fb = a_fdc.size();
        for (int i = 0; i < 2000 && a_fdc.size() <= fb; i++) tick(1);
        check("a_drain_results", 32'(a_vid.size() - vb), 32'd2);
        check("a_drain_ids", 32'({a_vid[vb], a_vid[vb+1]}), 32'({32'd0, 32'd1}));
        base = a_scyc.size();
        tick(3000);
        check("a_no_start_disabled", 32'(a_scyc.size()), 32'(base));
        enable = 1'b1; rel = cyc;
        for (int i = 0; i < 4000 && a_scyc.size() <= base; i++) tick(1);
        check("a_start_after_enable", 32'(a_scyc[base]), 32'(rel + 2750));

        // ---- EOC stuck low on ch0: timeout ----
        rst_n = 1'b0; stuck0 = 1'b1;
        tick(2);
        check("a_to_cleared", 32'(a_to), 32'd0);
        base = a_scyc.size(); vb = a_vid.size(); fb = a_fdc.size();
        rst_n = 1'b1;
        for (int i = 0; i < 12000 && a_fdc.size() <= fb; i++) tick(1);
        check("a_to_frame_done", 32'(a_fdc.size() - fb), 32'd1);
        check("a_timeout_err", 32'(a_to), 32'd1);
        check("a_to_results", 32'(a_vid.size() - vb), 32'd1);
        check("a_to_ch1", 32'({a_vid[vb], a_vdat[vb]}), 32'({32'd1, 32'hD6}));
        check("a_to_ch0_kept", 32'(a_data[7:0]), 32'd0);
        check("a_to_latency", 32'(a_scyc[base+1] - a_scyc[base]), 32'd4150);
        check("a_to_overrun", 32'(a_ovr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adc0809_scan_sequencer.md
Name: adc0809_scan_sequencer

Overview:
Parametrised successor to the fixed-period, single-channel ADC trigger and driver path that feeds the boost PID loop. The block owns the sample-period timer and drives an ADC0809 directly. It scans NUM_CH channels per frame and optionally averages 2^AVG_LOG2 conversions per channel. It publishes per-channel results with a valid strobe, so the PID and protection logic can consume voltage and current channels from one block.

Parameters:
NUM_CH, 2, number of channels scanned per frame, 1..8, channels 0..NUM_CH-1
SAMPLE_PERIOD, 2700, sys_clk cycles between frame triggers, >= 16
CLK_DIV, 25, adc_clk half-period in sys_clk cycles, >= 1
START_CYC, 4, width of the adc_start pulse in sys_clk cycles
OE_CYC, 4, oe high time before data is latched, in sys_clk cycles
AVG_LOG2, 0, log2 of conversions averaged per channel, 0..4
TIMEOUT, 4096, max sys_clk cycles from adc_start falling to EOC rising

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; frames are triggered only while high
adc_data_in  in  8  ADC0809 data bus
adc_eoc  in  1  ADC0809 end-of-conversion, asynchronous
adc_clk  out  1  ADC conversion clock
adc_start  out  1  START/ALE pulse
oe  out  1  ADC output enable
addr_a  out  1  channel address bit 0
addr_b  out  1  channel address bit 1
addr_c  out  1  channel address bit 2
ch_data  out  8*NUM_CH  result registers, channel k in bits [8k+7:8k]
ch_valid  out  1  one-cycle pulse when a channel result is written
ch_id  out  3  channel just written, valid with ch_valid
frame_done  out  1  one-cycle pulse after the last channel of a frame
overrun  out  1  sticky; a trigger arrived while a frame was busy
timeout_err  out  1  sticky; an EOC timeout occurred

Behaviour:
- Reset: all outputs 0, ch_data 0, FSM in IDLE, all counters 0. Reset mid-conversion aborts immediately. There is no recovery sequence.
- adc_clk: free-running divider, toggles every CLK_DIV sys_clk cycles, independent of the FSM.
- Period timer: counts 0..SAMPLE_PERIOD-1 and wraps. It produces a one-cycle trigger at wrap.
  - The timer runs only while enable is high. It is cleared while enable is low.
- adc_eoc: passes through a 2-flop synchronizer before use, which adds 2 cycles of latency.
- FSM states and transitions:
  - IDLE: on trigger, channel index := 0, accumulator := 0, go to ADDR.
  - ADDR: drive addr_c/b/a = channel index and hold it for the whole conversion. Wait 2*CLK_DIV cycles for settling, then go to START.
  - START: adc_start high for START_CYC cycles, then go to WAIT_LO.
  - WAIT_LO: wait for synchronized EOC low, then go to WAIT_HI.
  - WAIT_HI: wait for synchronized EOC high, then go to READ.
  - READ: oe high for OE_CYC cycles. Sample adc_data_in on the last oe cycle, then oe low and go to ACC.
  - ACC: accumulator += sample, 12 bits wide.
    - If the conversion count is below 2^AVG_LOG2, go to ADDR for the same channel.
    - Otherwise write ch_data[ch] := accumulator >> AVG_LOG2 (truncated), pulse ch_valid with ch_id = ch, and clear the accumulator.
    - Then, if ch < NUM_CH-1, increment ch and go to ADDR. Otherwise pulse frame_done one cycle after the last ch_valid and go to IDLE.
- Timeout:
  - A counter starts when adc_start falls and covers WAIT_LO and WAIT_HI.
  - At TIMEOUT: set timeout_err, leave ch_data[ch] unchanged, suppress ch_valid for that channel, clear the accumulator, and advance to the next channel.
  - If the timeout hits the last channel, frame_done still pulses.
- Overrun: a trigger while the FSM is not in IDLE sets overrun and is dropped. The frame in progress is not disturbed.
- Trigger in IDLE on the cycle enable falls: ignored.
- enable falling mid-frame: the current frame completes, no new trigger follows.
- overrun and timeout_err clear only on reset.
- ch_data registers hold their values between writes.
- At most one ch_valid per cycle.

Test Plan:
- NUM_CH=2, AVG_LOG2=0, ADC model returns 0x5A on ch0 and 0xD6 on ch1, EOC 64 cycles after start -> per frame: ch_valid/ch_id=0 with data 0x5A, then ch_id=1 with 0xD6, then frame_done; addr_a=0 then 1; triggers exactly 2700 cycles apart.
- AVG_LOG2=2, ch0 samples 10, 11, 12, 13 -> ch_data[7:0]=11 (46>>2), a single ch_valid, and exactly 4 adc_start pulses before it.
- EOC held low permanently on ch0 -> timeout_err=1 after TIMEOUT cycles; no ch_valid for ch0; ch1 still converts; frame_done pulses.
- SAMPLE_PERIOD=16 with a long conversion -> overrun=1; the in-flight frame still completes correctly; the next frame starts on the first trigger after IDLE.
- rst_n asserted during READ -> oe, adc_start, outputs and ch_data all 0 immediately; after release the first frame starts SAMPLE_PERIOD cycles later.
- enable dropped mid-frame -> the remaining channels complete, then no further adc_start; re-enable -> first trigger after SAMPLE_PERIOD cycles.
